// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the sprite/background mappers.
// The generator drives it (master); the mappers observe it (slave).
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );
    modport slave (
        input DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with sync outputs delayed to match
// the two-cycle pixel latency of the mappers.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // 11-bit bounds so a 1024-wide raster cannot alias to zero
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        run_q, run_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [10:0] h_w, v_w;
    logic        raw_hs, raw_vs;

    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        run_d       = run_q;
        frame_cnt_d = frame_cnt_q;
        if (!run_q) begin
            run_d = 1'b1;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d         = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            run_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            run_q       <= run_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign h_w = {1'b0, h_q};
    assign v_w = {1'b0, v_q};

    assign raw_hs = ~(run_q & (h_w >= HS_ON) & (h_w < HS_OFF));
    assign raw_vs = ~(run_q & (v_w >= VS_ON) & (v_w < VS_OFF));

    assign vga.DrawX       = h_q;
    assign vga.DrawY       = v_q;
    assign vga.blank       = run_q & (h_w < H_VIS) & (v_w < V_VIS);
    assign vga.frame_start = run_q & (h_q == '0) & (v_q == '0);
    assign vga.frame_count = frame_cnt_q;

    if (SYNC_DELAY == 0) begin : g_nodly
        assign vga.hs = raw_hs;
        assign vga.vs = raw_vs;
    end else begin : g_dly
        logic [SYNC_DELAY-1:0] hs_q;
        logic [SYNC_DELAY-1:0] vs_q;

        always_ff @(posedge vga_clk) begin
            if (reset) begin
                hs_q <= '1;
                vs_q <= '1;
            end else begin
                hs_q[0] <= raw_hs;
                vs_q[0] <= raw_vs;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_q[i] <= hs_q[i-1];
                    vs_q[i] <= vs_q[i-1];
                end
            end
        end

        assign vga.hs = hs_q[SYNC_DELAY-1];
        assign vga.vs = vs_q[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster for reset/line/mid-frame reset,
// a shrunken raster with SYNC_DELAY=0 for frame and counter wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic srst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if vif ();
    vga_timing_gen_if sif ();

    vga_timing_gen dut (
        .vga_clk (clk),
        .reset   (rst),
        .vga     (vif)
    );

    // 16x9 raster: hs low at x 10..12, vs low at y 5..6, no delay
    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (2),
        .SYNC_DELAY(0)
    ) sdut (
        .vga_clk (clk),
        .reset   (srst),
        .vga     (sif)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        step(5);
        n_cmp++; if (vif.DrawX !== 10'd0) begin n_bad++; $display("FAIL rst_x got %0d want 0", vif.DrawX); end
        n_cmp++; if (vif.DrawY !== 10'd0) begin n_bad++; $display("FAIL rst_y got %0d want 0", vif.DrawY); end
        n_cmp++; if (vif.blank !== 1'b0) begin n_bad++; $display("FAIL rst_blank got %0b want 0", vif.blank); end
        n_cmp++; if (vif.hs !== 1'b1) begin n_bad++; $display("FAIL rst_hs got %0b want 1", vif.hs); end
        n_cmp++; if (vif.vs !== 1'b1) begin n_bad++; $display("FAIL rst_vs got %0b want 1", vif.vs); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs got %0b want 0", vif.frame_start); end
        n_cmp++; if (vif.frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_fc got %0d want 0", vif.frame_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (vif.blank !== 1'b0) begin n_bad++; $display("FAIL rel_blank0 got %0b want 0", vif.blank); end
        step(1);
        n_cmp++; if (vif.blank !== 1'b1) begin n_bad++; $display("FAIL rel_blank got %0b want 1", vif.blank); end
        n_cmp++; if (vif.frame_start !== 1'b1) begin n_bad++; $display("FAIL rel_fs got %0b want 1", vif.frame_start); end
        n_cmp++; if (vif.DrawX !== 10'd0) begin n_bad++; $display("FAIL rel_x got %0d want 0", vif.DrawX); end
        step(1);
        n_cmp++; if (vif.DrawX !== 10'd1) begin n_bad++; $display("FAIL rel_x1 got %0d want 1", vif.DrawX); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL rel_fs1 got %0b want 0", vif.frame_start); end
    endtask

    task automatic test_line_wrap;
        int pos_err = 0;
        int blk_err = 0;
        int hs_low = 0;
        int hs_first = -1;
        int hs_last = -1;
        for (int i = 1; i < 800; i++) begin
            if (vif.DrawX !== 10'(i) || vif.DrawY !== 10'd0) pos_err++;
            if (vif.blank !== (i < 640)) blk_err++;
            if (vif.hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (i < 799) step(1);
        end
        n_cmp++; if (pos_err != 0) begin n_bad++; $display("FAIL line_pos errs got %0d want 0", pos_err); end
        n_cmp++; if (blk_err != 0) begin n_bad++; $display("FAIL line_blank errs got %0d want 0", blk_err); end
        n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL hs_len got %0d want 96", hs_low); end
        n_cmp++; if (hs_first != 658) begin n_bad++; $display("FAIL hs_first got %0d want 658", hs_first); end
        n_cmp++; if (hs_last != 753) begin n_bad++; $display("FAIL hs_last got %0d want 753", hs_last); end
        step(1);
        n_cmp++; if (vif.DrawX !== 10'd0) begin n_bad++; $display("FAIL wrap_x got %0d want 0", vif.DrawX); end
        n_cmp++; if (vif.DrawY !== 10'd1) begin n_bad++; $display("FAIL wrap_y got %0d want 1", vif.DrawY); end
        n_cmp++; if (vif.blank !== 1'b1) begin n_bad++; $display("FAIL wrap_blank got %0b want 1", vif.blank); end
    endtask

    task automatic test_mid_reset;
        int hs_low = 0;
        step(700);
        n_cmp++; if (vif.DrawX !== 10'd700) begin n_bad++; $display("FAIL mid_x got %0d want 700", vif.DrawX); end
        n_cmp++; if (vif.hs !== 1'b0) begin n_bad++; $display("FAIL mid_hs got %0b want 0", vif.hs); end
        rst = 1'b1;
        step(1);
        n_cmp++; if (vif.DrawX !== 10'd0) begin n_bad++; $display("FAIL mr_x got %0d want 0", vif.DrawX); end
        n_cmp++; if (vif.DrawY !== 10'd0) begin n_bad++; $display("FAIL mr_y got %0d want 0", vif.DrawY); end
        n_cmp++; if (vif.blank !== 1'b0) begin n_bad++; $display("FAIL mr_blank got %0b want 0", vif.blank); end
        n_cmp++; if (vif.hs !== 1'b1) begin n_bad++; $display("FAIL mr_hs got %0b want 1", vif.hs); end
        n_cmp++; if (vif.vs !== 1'b1) begin n_bad++; $display("FAIL mr_vs got %0b want 1", vif.vs); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL mr_fs got %0b want 0", vif.frame_start); end
        step(3);
        rst = 1'b0;
        step(1);
        n_cmp++; if (vif.frame_start !== 1'b1) begin n_bad++; $display("FAIL mr_rel_fs got %0b want 1", vif.frame_start); end
        n_cmp++; if (vif.blank !== 1'b1) begin n_bad++; $display("FAIL mr_rel_blank got %0b want 1", vif.blank); end
        for (int i = 0; i < 650; i++) begin
            step(1);
            if (vif.hs !== 1'b1) hs_low++;
        end
        n_cmp++; if (hs_low != 0) begin n_bad++; $display("FAIL mr_hs_glitch got %0d want 0", hs_low); end
        n_cmp++; if (vif.DrawX !== 10'd650) begin n_bad++; $display("FAIL mr_run_x got %0d want 650", vif.DrawX); end
    endtask

    task automatic test_small_frame;
        int ex = 0;
        int ey = 0;
        int pos_err = 0;
        int blk_err = 0;
        int hs_err = 0;
        int vs_err = 0;
        int fs_err = 0;
        int hs_low = 0;
        int vs_low = 0;
        srst = 1'b0;
        step(1);
        for (int n = 0; n < 144; n++) begin
            if (sif.DrawX !== 10'(ex) || sif.DrawY !== 10'(ey)) pos_err++;
            if (sif.blank !== (ex < 8 && ey < 4)) blk_err++;
            if (sif.hs !== !(ex >= 10 && ex < 13)) hs_err++;
            if (sif.vs !== !(ey >= 5 && ey < 7)) vs_err++;
            if (sif.frame_start !== (ex == 0 && ey == 0)) fs_err++;
            if (sif.frame_count !== 16'd0) fs_err++;
            if (sif.hs === 1'b0) hs_low++;
            if (sif.vs === 1'b0) vs_low++;
            step(1);
            ex++;
            if (ex == 16) begin
                ex = 0;
                ey++;
            end
        end
        n_cmp++; if (pos_err != 0) begin n_bad++; $display("FAIL s_pos errs got %0d want 0", pos_err); end
        n_cmp++; if (blk_err != 0) begin n_bad++; $display("FAIL s_blank errs got %0d want 0", blk_err); end
        n_cmp++; if (hs_err != 0) begin n_bad++; $display("FAIL s_hs errs got %0d want 0", hs_err); end
        n_cmp++; if (vs_err != 0) begin n_bad++; $display("FAIL s_vs errs got %0d want 0", vs_err); end
        n_cmp++; if (fs_err != 0) begin n_bad++; $display("FAIL s_fs errs got %0d want 0", fs_err); end
        n_cmp++; if (hs_low != 27) begin n_bad++; $display("FAIL s_hs_len got %0d want 27", hs_low); end
        n_cmp++; if (vs_low != 32) begin n_bad++; $display("FAIL s_vs_len got %0d want 32", vs_low); end
        n_cmp++; if (sif.DrawX !== 10'd0 || sif.DrawY !== 10'd0) begin n_bad++; $display("FAIL fw_pos got %0d,%0d want 0,0", sif.DrawX, sif.DrawY); end
        n_cmp++; if (sif.frame_start !== 1'b1) begin n_bad++; $display("FAIL fw_fs got %0b want 1", sif.frame_start); end
        n_cmp++; if (sif.frame_count !== 16'd1) begin n_bad++; $display("FAIL fw_fc got %0d want 1", sif.frame_count); end
    endtask

    task automatic test_count_wrap;
        step(20);
        force sdut.frame_cnt_q = 16'hFFFF;
        #1;
        release sdut.frame_cnt_q;
        #1;
        n_cmp++; if (sif.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL cw_set got %0d want 65535", sif.frame_count); end
        step(123);
        n_cmp++; if (sif.DrawX !== 10'd15 || sif.DrawY !== 10'd8) begin n_bad++; $display("FAIL cw_last got %0d,%0d want 15,8", sif.DrawX, sif.DrawY); end
        n_cmp++; if (sif.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL cw_hold got %0d want 65535", sif.frame_count); end
        step(1);
        n_cmp++; if (sif.frame_count !== 16'd0) begin n_bad++; $display("FAIL cw_wrap got %0d want 0", sif.frame_count); end
        n_cmp++; if (sif.frame_start !== 1'b1) begin n_bad++; $display("FAIL cw_fs got %0b want 1", sif.frame_start); end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_mid_reset();
        test_small_frame();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
